// File: rtl/alu_issue_ctrl.sv
// Instruction sequencer: fetches 16-bit words over a valid/ready stream, decodes them,
// and issues one single-cycle register-file/ALU command per instruction.
module alu_issue_ctrl #(
   parameter int unsigned          ADDR_W     = 16,
   parameter logic [ADDR_W-1:0]    RESET_ADDR = '0,
   parameter logic [7:0]           MAX_OPT    = 8'h10
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              i_start,
   input  logic              i_instr_valid,
   input  logic [15:0]       i_instr,
   output logic              o_instr_ready,
   output logic [ADDR_W-1:0] o_fetch_addr,
   output logic [7:0]        o_reg_selector,
   output logic              o_regop,
   output logic              o_store_in_reg,
   output logic [15:0]       o_data,
   output logic [7:0]        o_option,
   output logic              o_busy,
   output logic              o_halted,
   output logic              o_illegal
);

   localparam int unsigned REG_W = 3;

   localparam logic [1:0] CLS_ALU  = 2'b00;
   localparam logic [1:0] CLS_LDI  = 2'b01;
   localparam logic [1:0] CLS_NOP  = 2'b10;
   localparam logic [1:0] CLS_HALT = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_IMM,
      S_ISSUE,
      S_HALTED
   } state_t;

   state_t            state_q, state_nxt;
   logic [REG_W-1:0]  pend_dst_q, pend_dst_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   logic [7:0]        sel_nxt;
   logic [7:0]        opt_nxt;
   logic [15:0]       data_nxt;
   logic              regop_nxt;
   logic              store_nxt;
   logic              illegal_nxt;
   logic              ready_nxt;
   logic              busy_nxt;
   logic              halted_nxt;

   logic              take;
   logic [1:0]        w_cls;
   logic [REG_W-1:0]  w_dst;
   logic [REG_W-1:0]  w_src;
   logic [7:0]        w_opt;
   logic              w_opt_legal;

   // Instruction word field decode and handshake qualifier
   always_comb begin
      take        = o_instr_ready & i_instr_valid;
      w_cls       = i_instr[15:14];
      w_dst       = i_instr[13:11];
      w_src       = i_instr[10:8];
      w_opt       = i_instr[7:0];
      w_opt_legal = (w_opt <= MAX_OPT) || (w_opt == 8'hFF);
   end

   // State register and registered outputs
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q        <= S_IDLE;
         pend_dst_q     <= '0;
         o_fetch_addr   <= RESET_ADDR;
         o_reg_selector <= '0;
         o_option       <= '0;
         o_data         <= '0;
         o_regop        <= 1'b0;
         o_store_in_reg <= 1'b0;
         o_illegal      <= 1'b0;
         o_instr_ready  <= 1'b0;
         o_busy         <= 1'b0;
         o_halted       <= 1'b0;
      end else begin
         state_q        <= state_nxt;
         pend_dst_q     <= pend_dst_nxt;
         o_fetch_addr   <= addr_nxt;
         o_reg_selector <= sel_nxt;
         o_option       <= opt_nxt;
         o_data         <= data_nxt;
         o_regop        <= regop_nxt;
         o_store_in_reg <= store_nxt;
         o_illegal      <= illegal_nxt;
         o_instr_ready  <= ready_nxt;
         o_busy         <= busy_nxt;
         o_halted       <= halted_nxt;
      end
   end

   // Next-state and next-output decode; strobes default low so each lasts one cycle
   always_comb begin
      state_nxt    = state_q;
      pend_dst_nxt = pend_dst_q;
      addr_nxt     = o_fetch_addr;
      sel_nxt      = o_reg_selector;
      opt_nxt      = o_option;
      data_nxt     = o_data;
      regop_nxt    = 1'b0;
      store_nxt    = 1'b0;
      illegal_nxt  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_start) state_nxt = S_FETCH;
         end
         S_FETCH: begin
            if (take) begin
               addr_nxt = o_fetch_addr + ADDR_W'(1);
               case (w_cls)
                  CLS_ALU: begin
                     if (w_opt_legal) begin
                        sel_nxt   = {1'b0, w_dst, 1'b0, w_src};
                        opt_nxt   = w_opt;
                        regop_nxt = 1'b1;
                        state_nxt = S_ISSUE;
                     end else begin
                        illegal_nxt = 1'b1;
                     end
                  end
                  CLS_LDI: begin
                     pend_dst_nxt = w_dst;
                     state_nxt    = S_IMM;
                  end
                  CLS_NOP:  state_nxt = S_FETCH;
                  CLS_HALT: state_nxt = S_HALTED;
                  default:  state_nxt = S_FETCH;
               endcase
            end
         end
         S_IMM: begin
            if (take) begin
               addr_nxt  = o_fetch_addr + ADDR_W'(1);
               data_nxt  = i_instr;
               sel_nxt   = {5'b0, pend_dst_q};
               store_nxt = 1'b1;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_nxt = S_FETCH;
         end
         S_HALTED: begin
            if (i_start) state_nxt = S_FETCH;
         end
         default: state_nxt = S_IDLE;
      endcase

      ready_nxt  = (state_nxt == S_FETCH) || (state_nxt == S_IMM);
      busy_nxt   = (state_nxt == S_FETCH) || (state_nxt == S_IMM) || (state_nxt == S_ISSUE);
      halted_nxt = (state_nxt == S_HALTED);
   end

endmodule
